// File: rtl/mmio_copy_master.sv
// Bus initiator that copies word_cnt 32-bit words from a source range to a destination range,
// one READ/WRITE cycle pair per word, then pulses done.
module mmio_copy_master #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] word_cnt,
    input  logic [31:0]      mem_rd,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wd,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] words_left
);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [31:0]      data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Byte-offset bits are ignored; pointers are always word-aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{src_addr[1:0], dst_addr[1:0]};

    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (word_cnt != '0) begin
                        src_ptr_d = {src_addr[31:2], 2'b00};
                        dst_ptr_d = {dst_addr[31:2], 2'b00};
                        cnt_d     = word_cnt;
                        state_d   = StRead;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StRead: begin
                data_d  = mem_rd;
                state_d = StWrite;
            end
            StWrite: begin
                src_ptr_d = src_ptr_q + 32'd4;
                dst_ptr_d = dst_ptr_q + 32'd4;
                cnt_d     = cnt_q - CNT_W'(1);
                state_d   = (cnt_q == CNT_W'(1)) ? StDone : StRead;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decode from state and registers only; mem_rd never reaches an output directly.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = 32'h0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            StRead: begin
                mem_addr = src_ptr_q;
                busy     = 1'b1;
            end
            StWrite: begin
                mem_addr = dst_ptr_q;
                mem_we   = 1'b1;
                busy     = 1'b1;
            end
            StDone: begin
                done = 1'b1;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign mem_wd     = data_q;
    assign words_left = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            src_ptr_q <= 32'h0;
            dst_ptr_q <= 32'h0;
            data_q    <= 32'h0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mmio_copy_master.sv
// Scoreboard bench for mmio_copy_master: a bus memory model answers reads, expected reads, writes
// and done cycles are queued at issue time and checked by an independent negedge monitor.
module tb_mmio_copy_master;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] word_cnt;
    logic [31:0]      mem_rd;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wd;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] words_left;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    bit prev_we = 1'b0;

    logic [31:0] bus_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    logic [31:0] rq[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          dq[$];

    mmio_copy_master #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .word_cnt   (word_cnt),
        .mem_rd     (mem_rd),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .busy       (busy),
        .done       (done),
        .words_left (words_left)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        bus_mem[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        failed++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Bus model: writes commit at the edge, reads answer the address driven this cycle.
    always @(posedge clk) begin
        if (mem_we === 1'b1) bus_mem[mem_addr] = mem_wd;
    end

    always @(negedge clk) mem_rd <= bus_rd(mem_addr);

    // Monitor
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            chk("we_not_back_to_back", {31'h0, prev_we}, 32'h0);
            if (wa.size() == 0) begin
                flag("unexpected_write");
            end else begin
                chk("write_addr", mem_addr, wa.pop_front());
                chk("write_data", mem_wd, wd.pop_front());
            end
        end else if (busy === 1'b1) begin
            if (rq.size() == 0) flag("unexpected_read");
            else chk("read_addr", mem_addr, rq.pop_front());
        end
        if (done === 1'b1) begin
            if (dq.size() == 0) flag("unexpected_done");
            else chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
        end
        prev_we = (mem_we === 1'b1);
    end

    // Issues a start and queues what should follow; n_rd/n_wr allow for an aborted copy.
    task automatic issue(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                         input int n_rd, input int n_wr, input bit exp_done);
        logic [31:0] s, d, v;
        @(negedge clk);
        start    = 1'b1;
        src_addr = src;
        dst_addr = dst;
        word_cnt = CNT_W'(cnt);
        s = src & 32'hFFFF_FFFC;
        d = dst & 32'hFFFF_FFFC;
        for (int k = 0; k < n_rd; k++) rq.push_back(s + 32'(k * 4));
        for (int k = 0; k < n_wr; k++) begin
            v = ref_rd(s + 32'(k * 4));
            ref_mem[d + 32'(k * 4)] = v;
            wa.push_back(d + 32'(k * 4));
            wd.push_back(v);
        end
        if (exp_done) dq.push_back(cyc + 1 + 2 * cnt);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while ((dq.size() != 0 || busy || done) && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (dq.size() != 0 || busy || done) begin
            flag("timeout_waiting_for_done");
            dq.delete();
            rq.delete();
            wa.delete();
            wd.delete();
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;  // reset must win over start
        src_addr = 32'h0;
        dst_addr = 32'h40;
        word_cnt = 8'd4;
        preload(32'h0, 32'h11);
        preload(32'h4, 32'h22);
        preload(32'h8, 32'h33);
        preload(32'hC, 32'h44);
        repeat (3) @(negedge clk);
        chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_words_left", 32'(words_left), 32'h0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Basic 4-word copy with cycle-level busy / words_left profile
        issue(32'h0, 32'h40, 4, 4, 4, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            chk("copy4_busy", {31'h0, busy}, (i <= 8) ? 32'h1 : 32'h0);
            chk("copy4_words_left", 32'(words_left), 32'(4 - (i - 1) / 2));
            @(negedge clk);
        end
        wait_idle(50);
        chk("copy4_mem40", bus_rd(32'h40), 32'h11);
        chk("copy4_mem44", bus_rd(32'h44), 32'h22);
        chk("copy4_mem48", bus_rd(32'h48), 32'h33);
        chk("copy4_mem4c", bus_rd(32'h4C), 32'h44);

        // Zero-length request: done only
        issue(32'h10, 32'h80, 0, 0, 0, 1'b1);
        chk("cnt0_busy", {31'h0, busy}, 32'h0);
        wait_idle(20);

        // Misaligned addresses are truncated
        preload(32'h40, 32'h0);
        issue(32'h3, 32'h41, 1, 1, 1, 1'b1);
        wait_idle(20);
        chk("misaligned_mem40", bus_rd(32'h40), 32'h11);

        // Second start mid-transfer is ignored
        issue(32'h0, 32'h60, 4, 4, 4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        start    = 1'b1;
        src_addr = 32'h500;
        dst_addr = 32'h700;
        word_cnt = 8'd2;
        @(negedge clk);
        start = 1'b0;
        wait_idle(50);
        chk("ignored_mem6c", bus_rd(32'h6C), 32'h44);
        chk("ignored_mem700", bus_rd(32'h700), 32'h0);

        // Overlapping ranges: first word propagates upward
        preload(32'h100, 32'hA1);
        preload(32'h104, 32'hB2);
        preload(32'h108, 32'hC3);
        issue(32'h100, 32'h104, 3, 3, 3, 1'b1);
        wait_idle(50);
        chk("overlap_mem10c", bus_rd(32'h10C), 32'hA1);
        chk("overlap_mem108", bus_rd(32'h108), 32'hA1);

        // Source pointer wraps through zero
        preload(32'hFFFF_FFF8, 32'hDEAD_0001);
        preload(32'hFFFF_FFFC, 32'hDEAD_0002);
        issue(32'hFFFF_FFF8, 32'h20, 3, 3, 3, 1'b1);
        wait_idle(50);
        chk("wrap_mem20", bus_rd(32'h20), 32'hDEAD_0001);
        chk("wrap_mem28", bus_rd(32'h28), 32'h11);

        // Reset during READ of word 1: only word 0 lands, no done
        preload(32'h200, 32'h0BAD_0000);
        preload(32'h204, 32'h0BAD_0001);
        preload(32'h208, 32'h0BAD_0002);
        preload(32'h20C, 32'h0BAD_0003);
        issue(32'h200, 32'h300, 4, 2, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_mem_we", {31'h0, mem_we}, 32'h0);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("midrst_mem_we_t5", {31'h0, mem_we}, 32'h0);
        chk("midrst_busy_t5", {31'h0, busy}, 32'h0);
        chk("midrst_words_left_t5", 32'(words_left), 32'h0);
        issue(32'h208, 32'h400, 1, 1, 1, 1'b1);
        wait_idle(20);
        chk("midrst_mem300", bus_rd(32'h300), 32'h0BAD_0000);
        chk("midrst_mem304", bus_rd(32'h304), 32'h0);
        chk("after_rst_mem400", bus_rd(32'h400), 32'h0BAD_0002);

        repeat (3) @(negedge clk);
        chk("pending_reads", 32'(rq.size()), 32'h0);
        chk("pending_writes", 32'(wa.size()), 32'h0);
        chk("pending_dones", 32'(dq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mmio_copy_master.md
Name: mmio_copy_master

Overview:
- Bus-initiator block for the memory-mapped SoC data bus; it drives the same signals the MIPS core drives toward the address decoder: write enable, address, write data, and returned read data.
- Performs autonomous word copies: reads N words from a source address range and writes them to a destination address range.
- Destinations include data memory, the factorial accelerator window and the GPIO window.
- Sits beside the core behind a bus-ownership mux owned by the SoC top; this block only generates bus cycles while busy.

Parameters:
- CNT_W, 8, width of word-count input and remaining-count register (max transfer 2^CNT_W-1 words)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- src_addr  in  32  source byte address; bits [1:0] ignored (treated as 00)
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- word_cnt  in  CNT_W  number of 32-bit words to copy
- mem_rd  in  32  read data returned from bus mux; valid combinationally in the same cycle as mem_addr
- mem_we  out  1  bus write enable
- mem_addr  out  32  bus byte address, always word-aligned
- mem_wd  out  32  bus write data
- busy  out  1  high from the cycle after an accepted start through the last WRITE cycle
- done  out  1  one-cycle pulse when a transfer completes
- words_left  out  CNT_W  remaining words, for debug or GPIO readback

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE.
  - mem_we=0, mem_addr=0, mem_wd=0, busy=0, done=0, words_left=0.
  - Internal pointers and data latch are cleared.
  - Reset overrides start in the same cycle.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - mem_we=0, mem_addr=0, mem_wd holds the last value.
  - If start=1 and word_cnt!=0: latch src_ptr={src_addr[31:2],00}, dst_ptr={dst_addr[31:2],00}, words_left=word_cnt; next state READ.
  - If start=1 and word_cnt==0: no bus cycles; next state DONE.
- READ:
  - mem_addr=src_ptr, mem_we=0.
  - At the edge: data_reg<=mem_rd; next state WRITE.
- WRITE:
  - mem_addr=dst_ptr, mem_we=1, mem_wd=data_reg.
  - At the edge: src_ptr+=4, dst_ptr+=4, words_left-=1.
  - If words_left==1 (before decrement): next state DONE; else READ.
- DONE:
  - done=1 for exactly this cycle, mem_we=0, busy=0.
  - Next state IDLE.
  - A start asserted during DONE is ignored.
- Timing: start accepted in cycle t. Word k (0-based) is read in cycle t+1+2k and written in cycle t+2+2k. done pulses in cycle t+1+2N. The next start is accepted in cycle t+2+2N.
- busy=1 exactly in READ and WRITE states.
- start while busy or DONE is ignored; inputs src_addr, dst_addr and word_cnt may change freely after acceptance.
- Pointer arithmetic is 32-bit modulo: 0xFFFFFFFC+4 wraps to 0x00000000 with no error.
- mem_we is asserted only in WRITE and never for more than one consecutive cycle.
- Overlapping ranges: copy proceeds in ascending order word by word, with no overlap protection. If dst=src+4, the first word propagates.
- Reset mid-transfer: the next cycle is IDLE with mem_we=0. A partially copied range stays as written; no done pulse.
- All outputs are registered or decoded purely from state and internal registers; there is no combinational path from mem_rd to any output.

Test Plan:
- dmem words 0x00..0x0C = 0x11,0x22,0x33,0x44; start with src=0x00, dst=0x40, cnt=4 -> dmem 0x40..0x4C = 0x11..0x44; mem_we high in 4 cycles; done at t+9; busy high t+1..t+8.
- start with cnt=0 -> mem_we never asserted; done pulses at t+1; busy stays 0.
- src=0x03, dst=0x41, cnt=1 -> addresses driven 0x00 then 0x40; one word copied.
- During transfer of cnt=4, pulse start again with cnt=2 at t+3 -> ignored; still exactly 4 writes; single done at t+9.
- Assert rst at t+4 during a cnt=4 copy -> mem_we=0, busy=0, words_left=0 at t+5; only word 0 written; no done; a new start at t+6 is accepted normally.
- src=0xFFFFFFF8, dst=0x20, cnt=3 with bus model -> read addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; writes to 0x20, 0x24, 0x28.
